// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // True when a D-stage source operand is really read and names register rd.
    function automatic logic src_hit(input logic used, input logic [4:0] src, input logic [4:0] rd);
        return used && (src == rd);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard sequencer (slave).
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       d_rs1_index;
    logic [4:0]       d_rs2_index;
    logic             d_rs1_used;
    logic             d_rs2_used;
    logic [4:0]       e_rd_index;
    logic             e_is_load;
    logic             m_is_branch;
    logic             m_is_jalr;
    logic             m_branch_taken;
    logic             m_guess;
    logic [31:0]      m_jb_addr;
    logic [31:0]      m_pc;
    logic             m_ecall;
    logic             m_dm_access;
    logic             dm_ready;

    logic             stall_f;
    logic             stall_d;
    logic             stall_e;
    logic             stall_m;
    logic             flush_d;
    logic             flush_e;
    logic             flush_m;
    logic             redirect_en;
    logic [31:0]      redirect_pc;
    logic             bp_upd_en;
    logic             bp_upd_taken;
    logic [31:0]      bp_upd_pc;
    logic             halt;
    logic             mem_err;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output d_rs1_index, d_rs2_index, d_rs1_used, d_rs2_used,
               e_rd_index, e_is_load,
               m_is_branch, m_is_jalr, m_branch_taken, m_guess,
               m_jb_addr, m_pc, m_ecall, m_dm_access, dm_ready,
        input  stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m,
               redirect_en, redirect_pc,
               bp_upd_en, bp_upd_taken, bp_upd_pc,
               halt, mem_err, mispredict_cnt, stall_cnt
    );

    modport slave (
        input  d_rs1_index, d_rs2_index, d_rs1_used, d_rs2_used,
               e_rd_index, e_is_load,
               m_is_branch, m_is_jalr, m_branch_taken, m_guess,
               m_jb_addr, m_pc, m_ecall, m_dm_access, dm_ready,
        output stall_f, stall_d, stall_e, stall_m,
               flush_d, flush_e, flush_m,
               redirect_en, redirect_pc,
               bp_upd_en, bp_upd_taken, bp_upd_pc,
               halt, mem_err, mispredict_cnt, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Count on the pipeline edge; hold once every bit is set.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RUN      | normal flow: resolve mispredicts, load-use bubbles, ecall
//   MEM_WAIT | data memory busy: whole pipe frozen until dm_ready
//   HALT     | core stopped (ecall or memory timeout); only rst leaves
//
// Outputs are combinational from state and stage inputs so that redirects
// and bubbles take effect in the same cycle they are detected.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);

    localparam bit          TIMEOUT_ON   = (MEM_TIMEOUT != 0);
    localparam logic [31:0] TIMEOUT_LAST = 32'(MEM_TIMEOUT - 1);

    hz_state_t   state;
    hz_state_t   state_nxt;
    logic [31:0] wait_cnt;
    logic [31:0] wait_cnt_nxt;
    logic        mem_err_q;
    logic        mem_err_nxt;

    logic        mispredict;
    logic        load_use;
    logic        mem_busy;

    logic        stall_f_c;
    logic        stall_d_c;
    logic        stall_e_c;
    logic        stall_m_c;
    logic        flush_d_c;
    logic        flush_e_c;
    logic        flush_m_c;
    logic        redirect_en_c;
    logic [31:0] redirect_pc_c;
    logic        bp_upd_en_c;
    logic        mispredict_evt;
    logic        stall_evt;

    logic [CNT_W-1:0] mispredict_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;

    // Raw hazard conditions from the D, E and M stage fields.
    always_comb begin
        mispredict = hz.m_is_jalr | (hz.m_is_branch & (hz.m_branch_taken != hz.m_guess));
        load_use   = hz.e_is_load && (hz.e_rd_index != REG_ZERO) &&
                     (src_hit(hz.d_rs1_used, hz.d_rs1_index, hz.e_rd_index) ||
                      src_hit(hz.d_rs2_used, hz.d_rs2_index, hz.e_rd_index));
        mem_busy   = hz.m_dm_access && !hz.dm_ready;
    end

    // State, wait counter and sticky error flag advance with the pipeline registers.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
        end
    end

    // Next state and stall/flush/redirect decisions, RUN priority ecall > mispredict > memory > load-use.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        mem_err_nxt    = mem_err_q;
        stall_f_c      = 1'b0;
        stall_d_c      = 1'b0;
        stall_e_c      = 1'b0;
        stall_m_c      = 1'b0;
        flush_d_c      = 1'b0;
        flush_e_c      = 1'b0;
        flush_m_c      = 1'b0;
        redirect_en_c  = 1'b0;
        redirect_pc_c  = '0;
        bp_upd_en_c    = 1'b0;
        mispredict_evt = 1'b0;

        unique case (state)
            RUN: begin
                wait_cnt_nxt = '0;
                bp_upd_en_c  = hz.m_is_branch;
                if (hz.m_ecall) begin
                    // The ecall itself retires; younger instructions are squashed.
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                    state_nxt = HALT;
                end else if (mispredict) begin
                    redirect_en_c  = 1'b1;
                    redirect_pc_c  = (hz.m_is_jalr || hz.m_branch_taken) ? hz.m_jb_addr
                                                                         : hz.m_pc + PC_STEP;
                    flush_d_c      = 1'b1;
                    flush_e_c      = 1'b1;
                    flush_m_c      = 1'b1;
                    mispredict_evt = 1'b1;
                end else if (mem_busy) begin
                    // First busy cycle already freezes the pipe.
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    stall_m_c = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (load_use) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end

            MEM_WAIT: begin
                if (hz.dm_ready) begin
                    // Access completes now; the pipe advances this same cycle.
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    stall_f_c    = 1'b1;
                    stall_d_c    = 1'b1;
                    stall_e_c    = 1'b1;
                    stall_m_c    = 1'b1;
                    wait_cnt_nxt = wait_cnt + 32'd1;
                    if (TIMEOUT_ON && (wait_cnt_nxt >= TIMEOUT_LAST)) begin
                        state_nxt   = HALT;
                        mem_err_nxt = 1'b1;
                    end
                end
            end

            HALT: begin
                // Freeze everything and keep killing the E/M input so nothing writes back.
                stall_f_c = 1'b1;
                stall_d_c = 1'b1;
                stall_e_c = 1'b1;
                stall_m_c = 1'b1;
                flush_m_c = 1'b1;
            end

            default: begin
                state_nxt = RUN;
            end
        endcase

        stall_evt = stall_f_c && (state != HALT);
    end

    sat_counter #(.WIDTH(CNT_W)) u_mispredict_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mispredict_evt),
        .count (mispredict_cnt_q)
    );

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_evt),
        .count (stall_cnt_q)
    );

    // Reset forces every output low at once, even while stage inputs are active.
    assign hz.stall_f        = rst & stall_f_c;
    assign hz.stall_d        = rst & stall_d_c;
    assign hz.stall_e        = rst & stall_e_c;
    assign hz.stall_m        = rst & stall_m_c;
    assign hz.flush_d        = rst & flush_d_c;
    assign hz.flush_e        = rst & flush_e_c;
    assign hz.flush_m        = rst & flush_m_c;
    assign hz.redirect_en    = rst & redirect_en_c;
    assign hz.redirect_pc    = rst ? redirect_pc_c : '0;
    assign hz.bp_upd_en      = rst & bp_upd_en_c;
    assign hz.bp_upd_taken   = rst & hz.m_branch_taken;
    assign hz.bp_upd_pc      = rst ? hz.m_pc : '0;
    assign hz.halt           = rst & (state == HALT);
    assign hz.mem_err        = mem_err_q;
    assign hz.mispredict_cnt = mispredict_cnt_q;
    assign hz.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vectors, a rule-level reference model
// checked every cycle, plus hand-computed literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;
    localparam int CMAX        = (1 << CNT_W) - 1;

    logic clk;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state, expressed as plain facts about the core.
    bit m_halted  = 0;
    bit m_waiting = 0;
    int m_waited  = 0;
    bit m_mem_err = 0;
    int m_mis     = 0;
    int m_stall   = 0;

    typedef struct {
        logic        stall_f, stall_d, stall_e, stall_m;
        logic        flush_d, flush_e, flush_m;
        logic        redirect_en, bp_upd_en, bp_upd_taken, halt, mem_err;
        logic [31:0] redirect_pc, bp_upd_pc;
        int          mis_cnt, stall_cnt;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t predict();
        exp_t e;
        bit   mis;
        bit   lu;
        e = '{default: 0};
        if (!rst) return e;
        e.mis_cnt      = m_mis;
        e.stall_cnt    = m_stall;
        e.mem_err      = m_mem_err;
        e.halt         = m_halted;
        e.bp_upd_taken = hz.m_branch_taken;
        e.bp_upd_pc    = hz.m_pc;
        if (m_halted) begin
            {e.stall_f, e.stall_d, e.stall_e, e.stall_m, e.flush_m} = 5'b11111;
        end else if (m_waiting) begin
            if (!hz.dm_ready) {e.stall_f, e.stall_d, e.stall_e, e.stall_m} = 4'b1111;
        end else begin
            e.bp_upd_en = hz.m_is_branch;
            mis = hz.m_is_jalr || (hz.m_is_branch && (hz.m_branch_taken != hz.m_guess));
            lu  = hz.e_is_load && (hz.e_rd_index != 0) &&
                  ((hz.d_rs1_used && hz.d_rs1_index == hz.e_rd_index) ||
                   (hz.d_rs2_used && hz.d_rs2_index == hz.e_rd_index));
            if (hz.m_ecall) begin
                e.flush_d = 1; e.flush_e = 1;
            end else if (mis) begin
                e.redirect_en = 1;
                e.redirect_pc = (hz.m_is_jalr || hz.m_branch_taken) ? hz.m_jb_addr : hz.m_pc + 32'd4;
                e.flush_d = 1; e.flush_e = 1; e.flush_m = 1;
            end else if (hz.m_dm_access && !hz.dm_ready) begin
                {e.stall_f, e.stall_d, e.stall_e, e.stall_m} = 4'b1111;
            end else if (lu) begin
                e.stall_f = 1; e.stall_d = 1; e.flush_e = 1;
            end
        end
        return e;
    endfunction

    task automatic advance(input exp_t e);
        if (!rst) begin
            m_halted = 0; m_waiting = 0; m_waited = 0; m_mem_err = 0; m_mis = 0; m_stall = 0;
            return;
        end
        if (e.redirect_en && m_mis < CMAX) m_mis++;
        if (e.stall_f && !m_halted && m_stall < CMAX) m_stall++;
        if (m_halted) begin
        end else if (m_waiting) begin
            if (hz.dm_ready) m_waiting = 0;
            else begin
                m_waited++;
                if (m_waited >= MEM_TIMEOUT) begin
                    m_halted = 1; m_mem_err = 1; m_waiting = 0;
                end
            end
        end else if (hz.m_ecall) begin
            m_halted = 1;
        end else if (e.redirect_en) begin
        end else if (hz.m_dm_access && !hz.dm_ready) begin
            m_waiting = 1; m_waited = 1;
        end
    endtask

    // Every cycle: compare all outputs mid-cycle, then step the model on the pipeline edge.
    always begin : compare
        exp_t e;
        @(posedge clk);
        #1;
        e = predict();
        chk("stall_f", hz.stall_f, e.stall_f);
        chk("stall_d", hz.stall_d, e.stall_d);
        chk("stall_e", hz.stall_e, e.stall_e);
        chk("stall_m", hz.stall_m, e.stall_m);
        chk("flush_d", hz.flush_d, e.flush_d);
        chk("flush_e", hz.flush_e, e.flush_e);
        chk("flush_m", hz.flush_m, e.flush_m);
        chk("redirect_en", hz.redirect_en, e.redirect_en);
        chk("redirect_pc", hz.redirect_pc, e.redirect_pc);
        chk("bp_upd_en", hz.bp_upd_en, e.bp_upd_en);
        chk("bp_upd_taken", hz.bp_upd_taken, e.bp_upd_taken);
        chk("bp_upd_pc", hz.bp_upd_pc, e.bp_upd_pc);
        chk("halt", hz.halt, e.halt);
        chk("mem_err", hz.mem_err, e.mem_err);
        chk("mispredict_cnt", 32'(hz.mispredict_cnt), 32'(e.mis_cnt));
        chk("stall_cnt", 32'(hz.stall_cnt), 32'(e.stall_cnt));
        @(negedge clk);
        advance(e);
    end

    task automatic idle();
        hz.d_rs1_index = 0; hz.d_rs2_index = 0; hz.d_rs1_used = 0; hz.d_rs2_used = 0;
        hz.e_rd_index = 0; hz.e_is_load = 0;
        hz.m_is_branch = 0; hz.m_is_jalr = 0; hz.m_branch_taken = 0; hz.m_guess = 0;
        hz.m_jb_addr = 0; hz.m_pc = 0; hz.m_ecall = 0; hz.m_dm_access = 0; hz.dm_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic set_branch(input logic guess, input logic taken, input logic [31:0] pc, input logic [31:0] tgt);
        hz.m_is_branch = 1; hz.m_guess = guess; hz.m_branch_taken = taken;
        hz.m_pc = pc; hz.m_jb_addr = tgt;
    endtask

    task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2);
        hz.e_is_load = 1; hz.e_rd_index = rd;
        hz.d_rs1_index = rs1; hz.d_rs1_used = u1; hz.d_rs2_index = rs2; hz.d_rs2_used = u2;
    endtask

    task automatic pulse_reset_check();
        #1 rst = 1'b0;
        #1;
        chk("rst_halt", hz.halt, 1'b0);
        chk("rst_mem_err", hz.mem_err, 1'b0);
        chk("rst_stall_f", hz.stall_f, 1'b0);
        chk("rst_flush_m", hz.flush_m, 1'b0);
        chk("rst_redirect_en", hz.redirect_en, 1'b0);
        chk("rst_bp_upd_en", hz.bp_upd_en, 1'b0);
        chk("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        chk("rst_mis_cnt", 32'(hz.mispredict_cnt), 32'd0);
        nxt();
        rst = 1'b1;
        idle();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1;
        idle();
        #1 rst = 1'b0;
        nxt();
        nxt();
        rst = 1'b1;
        cyc();
        chk("reset_stall_f", hz.stall_f, 1'b0);
        chk("reset_halt", hz.halt, 1'b0);
        chk("reset_mis_cnt", 32'(hz.mispredict_cnt), 32'd0);
        nxt();

        // Predicted not-taken, resolves taken.
        set_branch(1'b0, 1'b1, 32'h40, 32'h100);
        cyc();
        chk("t1_redirect_en", hz.redirect_en, 1'b1);
        chk("t1_redirect_pc", hz.redirect_pc, 32'h100);
        chk("t1_flush_dem", {29'd0, hz.flush_d, hz.flush_e, hz.flush_m}, 32'd7);
        nxt();
        idle();
        cyc();
        chk("t1_one_cycle", hz.redirect_en, 1'b0);
        chk("t1_mis_cnt", 32'(hz.mispredict_cnt), 32'd1);
        nxt();

        // Predicted taken, resolves not-taken at the top of the address space.
        set_branch(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h200);
        cyc();
        chk("t2_redirect_pc_wrap", hz.redirect_pc, 32'h0);
        chk("t2_bp_upd_en", hz.bp_upd_en, 1'b1);
        chk("t2_bp_upd_taken", hz.bp_upd_taken, 1'b0);
        nxt();

        // jalr always redirects and never trains.
        idle();
        hz.m_is_jalr = 1; hz.m_jb_addr = 32'h1234; hz.m_pc = 32'h80;
        cyc();
        chk("t2b_jalr_pc", hz.redirect_pc, 32'h1234);
        chk("t2b_jalr_bp", hz.bp_upd_en, 1'b0);
        nxt();
        idle();

        // Load to x5 in E, D reads rs2=x5.
        set_load_use(5'd5, 5'd1, 1'b1, 5'd5, 1'b1);
        cyc();
        chk("t3_stall_fd", {30'd0, hz.stall_f, hz.stall_d}, 32'd3);
        chk("t3_flush_e", hz.flush_e, 1'b1);
        chk("t3_stall_e", hz.stall_e, 1'b0);
        nxt();
        idle();
        cyc();
        chk("t3_released", hz.stall_f, 1'b0);
        chk("t3_stall_cnt", 32'(hz.stall_cnt), 32'd1);
        nxt();
        set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        cyc();
        chk("t3_x0_no_stall", hz.stall_f, 1'b0);
        nxt();
        set_load_use(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        cyc();
        chk("t3_unused_src", hz.stall_f, 1'b0);
        nxt();
        set_load_use(5'd7, 5'd7, 1'b1, 5'd3, 1'b1);
        cyc();
        chk("t3_rs1_hit", hz.stall_f, 1'b1);
        nxt();

        // Load-use together with a mispredict: mispredict wins.
        set_branch(1'b0, 1'b1, 32'h300, 32'h500);
        cyc();
        chk("t4_no_stall", hz.stall_f, 1'b0);
        chk("t4_flush_dem", {29'd0, hz.flush_d, hz.flush_e, hz.flush_m}, 32'd7);
        chk("t4_mis_cnt", 32'(hz.mispredict_cnt), 32'd3);
        nxt();
        idle();

        // Memory busy for 3 cycles, then ready.
        hz.m_dm_access = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t5_stall_all", {28'd0, hz.stall_f, hz.stall_d, hz.stall_e, hz.stall_m}, 32'hF);
            chk("t5_no_flush", {29'd0, hz.flush_d, hz.flush_e, hz.flush_m}, 32'd0);
            nxt();
        end
        hz.dm_ready = 1;
        cyc();
        chk("t5_release", hz.stall_m, 1'b0);
        nxt();
        cyc();
        chk("t5_ready_in_run", hz.stall_f, 1'b0);
        chk("t5_stall_cnt", 32'(hz.stall_cnt), 32'd5);
        nxt();

        // Memory never ready: timeout after MEM_TIMEOUT stalled cycles.
        hz.dm_ready = 0;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            cyc();
            chk("t6_waiting", hz.halt, 1'b0);
            nxt();
        end
        cyc();
        chk("t6_halt", hz.halt, 1'b1);
        chk("t6_mem_err", hz.mem_err, 1'b1);
        chk("t6_stall_cnt", 32'(hz.stall_cnt), 32'd9);
        pulse_reset_check();

        // ecall: squash younger work, then stay halted whatever the inputs do.
        hz.m_ecall = 1;
        cyc();
        chk("t7_flush_de", {30'd0, hz.flush_d, hz.flush_e}, 32'd3);
        chk("t7_flush_m", hz.flush_m, 1'b0);
        chk("t7_not_yet", hz.halt, 1'b0);
        nxt();
        for (int i = 0; i < 20; i++) begin
            idle();
            case (i % 3)
                0: set_branch(1'b0, 1'b1, 32'h10, 32'h20);
                1: set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
                default: begin hz.m_dm_access = 1; hz.dm_ready = 1'(i % 2); end
            endcase
            hz.m_ecall = 1'(i % 2);
            cyc();
            chk("t7_halt", hz.halt, 1'b1);
            chk("t7_no_redirect", hz.redirect_en, 1'b0);
            chk("t7_flush_m_held", hz.flush_m, 1'b1);
            nxt();
        end
        idle();
        set_branch(1'b0, 1'b1, 32'h10, 32'h20);
        cyc();
        pulse_reset_check();
        cyc();
        chk("t7_after_reset", hz.halt, 1'b0);
        nxt();

        // Counter saturation.
        set_load_use(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
        for (int i = 0; i < CMAX + 3; i++) nxt();
        cyc();
        chk("t8_stall_sat", 32'(hz.stall_cnt), 32'(CMAX));
        nxt();
        idle();
        set_branch(1'b1, 1'b0, 32'h44, 32'h88);
        for (int i = 0; i < CMAX + 2; i++) nxt();
        cyc();
        chk("t8_mis_sat", 32'(hz.mispredict_cnt), 32'(CMAX));
        nxt();
        idle();
        nxt();
        nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
